imem_ctrl: RTL and testbench

IMEM_CTRL -- requirements
Module: imem_ctrl

---
 rtl/imem_pkg.sv | 9 +
 rtl/imem_rr_arb.sv | 17 +
 rtl/imem_ctrl.sv | 101 ++++++++++
 tb/tb_imem_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the instruction memory controller
package imem_pkg;
   localparam int ADDR_W = 8;
   localparam int BYTE_W = 8;
   localparam logic [1:0] OPC_FULL = 2'b11;
   localparam int G_FETCH = 0;
   localparam int G_LOAD = 1;
   typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;
endpackage

// File: rtl/imem_rr_arb.sv
// imem_rr_arb: two-way round-robin arbiter between fetch and loader, granting only while idle
module imem_rr_arb import imem_pkg::*; (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       idle,
   output logic [1:0] gnt
);
   logic last_ld;
   assign gnt[G_FETCH] = idle && req[G_FETCH] && (!req[G_LOAD] || last_ld);
   assign gnt[G_LOAD] = idle && req[G_LOAD] && (!req[G_FETCH] || !last_ld);
   // pointer starts as if the loader was served last, so fetch wins first
   always_ff @(posedge clk) begin
      if (!reset) last_ld <= 1'b1;
      else if (|gnt) last_ld <= gnt[G_LOAD];
   end
endmodule

// File: rtl/imem_ctrl.sv
// imem_ctrl: byte-wide instruction memory controller serving a loader and a 16/32-bit instruction fetch port
module imem_ctrl import imem_pkg::*; #(
   parameter int ADDR_W = imem_pkg::ADDR_W,
   parameter int BYTE_W = imem_pkg::BYTE_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ld_valid,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [BYTE_W-1:0] ld_data,
   output logic              ld_ready,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_gnt,
   output logic              f_rvalid,
   output logic [31:0]       f_rdata,
   output logic              f_compressed,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [BYTE_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_oe,
   input  logic [BYTE_W-1:0] mem_rdata
);
   state_t state;
   logic [1:0] gnt;
   logic [1:0] k;
   logic [1:0] last;
   logic cmp;
   logic cmp_now;
   logic [3*BYTE_W-1:0] sh;
   imem_rr_arb u_arb (
      .clk  (clk),
      .reset(reset),
      .req  ({ld_valid, f_req}),
      .idle (state == IDLE),
      .gnt  (gnt)
   );
   assign ld_ready = gnt[G_LOAD];
   assign f_gnt = gnt[G_FETCH];
   // byte0 lands while byte1 is being addressed, so the length decision uses it directly
   always_comb begin
      cmp_now = (mem_oe && k == 2'd1) ? (mem_rdata[1:0] != OPC_FULL) : cmp;
      last = cmp_now ? 2'd1 : 2'd3;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         mem_addr <= '0;
         mem_wdata <= '0;
         mem_we <= 1'b0;
         mem_oe <= 1'b0;
         f_rvalid <= 1'b0;
         f_rdata <= '0;
         f_compressed <= 1'b0;
         k <= '0;
         cmp <= 1'b0;
         sh <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt[G_LOAD]) begin
                  state <= WRITE;
                  mem_we <= 1'b1;
                  mem_addr <= ld_addr;
                  mem_wdata <= ld_data;
               end else if (gnt[G_FETCH]) begin
                  state <= READ;
                  mem_oe <= 1'b1;
                  mem_addr <= f_addr;
                  k <= '0;
               end
            end
            WRITE: begin
               mem_we <= 1'b0;
               state <= IDLE;
            end
            READ: begin
               cmp <= cmp_now;
               // data trails the address by one cycle; the final byte is taken straight from mem_rdata
               if (mem_oe && k != 2'd0) sh <= {mem_rdata, sh[3*BYTE_W-1:BYTE_W]};
               if (!mem_oe) begin
                  state <= RESP;
                  f_rvalid <= 1'b1;
                  f_compressed <= cmp;
                  f_rdata <= cmp ? {16'h0, mem_rdata, sh[3*BYTE_W-1 -: BYTE_W]} : {mem_rdata, sh};
               end else if (k == last) begin
                  mem_oe <= 1'b0;
               end else begin
                  k <= k + 2'd1;
                  mem_addr <= mem_addr + 1'b1;
               end
            end
            RESP: begin
               f_rvalid <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_imem_ctrl.sv
// tb_imem_ctrl: scoreboard bench with a byte memory model and a cycle-level reference of grants and responses
module tb_imem_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic ld_valid = 1'b0;
   logic f_req = 1'b0;
   logic [7:0] ld_addr = 8'h0;
   logic [7:0] ld_data = 8'h0;
   logic [7:0] f_addr = 8'h0;
   logic [7:0] mem_rdata;
   logic ld_ready, f_gnt, f_rvalid, f_compressed, mem_we, mem_oe;
   logic [31:0] f_rdata;
   logic [7:0] mem_addr, mem_wdata;
   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;
   typedef struct { int c; logic [7:0] a; logic [7:0] d; } wr_t;
   typedef struct { int c; logic [7:0] a; } rd_t;
   typedef struct { int c; logic [31:0] d; logic cm; } rsp_t;
   wr_t wq[$];
   rd_t aq[$];
   rsp_t rq[$];

   imem_ctrl dut (
      .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
      .ld_ready(ld_ready), .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
      .f_rdata(f_rdata), .f_compressed(f_compressed), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .mem_oe(mem_oe), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", n, a, e, cyc);
      end
   endtask

   task automatic fail(input string n);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: event at cycle %0d not matched", n, cyc);
   endtask

   function automatic logic [7:0] init_val(input int i);
      return 8'((i * 151 + 7) ^ (i >> 2));
   endfunction

   // the Imem itself: registered read one cycle after mem_oe
   logic [7:0] mem [256];
   bit mem_init = 1'b0;
   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] = init_val(i);
         mem_init = 1'b1;
      end
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_oe) mem_rdata <= mem[mem_addr];
   end

   // reference: block is busy for a fixed number of cycles per transaction; arbitration alternates on contention
   logic [7:0] ref_mem [256];
   bit ref_init = 1'b0;
   int free_at = 0;
   bit last_ld = 1'b1;
   always @(negedge clk) begin
      logic eg_f, eg_l, cm;
      logic [7:0] b [4];
      logic [7:0] a;
      if (!ref_init) begin
         for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
         ref_init = 1'b1;
      end
      if (!reset) begin
         wq.delete();
         aq.delete();
         rq.delete();
         free_at = cyc + 1;
         last_ld = 1'b1;
      end else begin
         eg_f = (cyc >= free_at) && f_req && (!ld_valid || last_ld);
         eg_l = (cyc >= free_at) && ld_valid && (!f_req || !last_ld);
         chk("grant", 64'({ld_ready, f_gnt}), 64'({eg_l, eg_f}));
         if (eg_l) begin
            ref_mem[ld_addr] = ld_data;
            wq.push_back('{c: cyc + 1, a: ld_addr, d: ld_data});
            free_at = cyc + 2;
            last_ld = 1'b1;
         end else if (eg_f) begin
            for (int i = 0; i < 4; i++) begin
               a = f_addr + 8'(i);
               b[i] = ref_mem[a];
            end
            cm = b[0][1:0] != 2'b11;
            for (int i = 0; i < (cm ? 2 : 4); i++) begin
               a = f_addr + 8'(i);
               aq.push_back('{c: cyc + 1 + i, a: a});
            end
            rq.push_back('{c: cyc + (cm ? 4 : 6), d: cm ? {16'h0, b[1], b[0]} : {b[3], b[2], b[1], b[0]}, cm: cm});
            free_at = cyc + (cm ? 5 : 7);
            last_ld = 1'b0;
         end
      end
   end

   // monitor: pops expectations whenever the DUT presents a memory access or a response
   always @(posedge clk) begin
      wr_t w;
      rd_t r;
      rsp_t p;
      #1;
      if (cyc >= 1) begin
         chk("we_oe_excl", 64'(mem_we & mem_oe), 64'(0));
         while (wq.size() > 0 && wq[0].c < cyc) begin fail("wr_missed"); void'(wq.pop_front()); end
         while (aq.size() > 0 && aq[0].c < cyc) begin fail("rd_missed"); void'(aq.pop_front()); end
         while (rq.size() > 0 && rq[0].c < cyc) begin fail("rsp_missed"); void'(rq.pop_front()); end
         if (mem_we) begin
            if (wq.size() == 0) fail("wr_unexpected");
            else begin
               w = wq.pop_front();
               chk("wr", 64'({cyc, mem_addr, mem_wdata}), 64'({w.c, w.a, w.d}));
            end
         end
         if (mem_oe) begin
            if (aq.size() == 0) fail("rd_unexpected");
            else begin
               r = aq.pop_front();
               chk("rd_addr", 64'({cyc, mem_addr}), 64'({r.c, r.a}));
            end
         end
         if (f_rvalid) begin
            if (rq.size() == 0) fail("rsp_unexpected");
            else begin
               p = rq.pop_front();
               chk("rsp", {cyc, f_rdata}, {p.c, p.d});
               chk("rsp_cmp", 64'(f_compressed), 64'(p.cm));
            end
         end
      end
   end

   task automatic chk_reset_outputs(input string n);
      chk({n, "_addr"}, 64'(mem_addr), 64'(0));
      chk({n, "_wdata"}, 64'(mem_wdata), 64'(0));
      chk({n, "_we"}, 64'(mem_we), 64'(0));
      chk({n, "_oe"}, 64'(mem_oe), 64'(0));
      chk({n, "_rvalid"}, 64'(f_rvalid), 64'(0));
      chk({n, "_rdata"}, 64'(f_rdata), 64'(0));
      chk({n, "_cmp"}, 64'(f_compressed), 64'(0));
   endtask

   task automatic ld(input logic [7:0] a, input logic [7:0] d);
      int g = -1;
      @(posedge clk); #1;
      ld_valid = 1'b1;
      ld_addr = a;
      ld_data = d;
      for (int t = 0; t < 30; t++) begin
         @(negedge clk);
         if (ld_ready) begin g = cyc; break; end
      end
      @(posedge clk); #1;
      ld_valid = 1'b0;
      if (g < 0) begin fail("ld_timeout"); return; end
      chk("ld_g1", 64'({mem_we, mem_addr, mem_wdata}), 64'({1'b1, a, d}));
      @(posedge clk); #1;
      chk("ld_g2_we", 64'(mem_we), 64'(0));
   endtask

   task automatic fetch(input logic [7:0] a, input logic [31:0] d, input logic c, input int lat);
      int g = -1;
      int r = -1;
      @(posedge clk); #1;
      f_req = 1'b1;
      f_addr = a;
      for (int t = 0; t < 30; t++) begin
         @(negedge clk);
         if (f_gnt) begin g = cyc; break; end
      end
      @(posedge clk); #1;
      f_req = 1'b0;
      if (g < 0) begin fail("fetch_timeout"); return; end
      for (int t = 0; t < 12; t++) begin
         if (f_rvalid) begin r = cyc; break; end
         @(posedge clk); #1;
      end
      chk("f_latency", 64'(r - g), 64'(lat));
      chk("f_rdata", 64'(f_rdata), 64'(d));
      chk("f_compressed", 64'(f_compressed), 64'(c));
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      int seq[$];
      int g;
      bit lg, fg;
      ld_valid = 1'b1;
      f_req = 1'b1;
      ld_addr = 8'h80;
      ld_data = 8'h5A;
      f_addr = 8'h40;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      reset = 1'b1;
      for (int t = 0; t < 80 && seq.size() < 4; t++) begin
         @(negedge clk);
         if (f_gnt) seq.push_back(0);
         else if (ld_ready) seq.push_back(1);
      end
      @(posedge clk); #1;
      ld_valid = 1'b0;
      f_req = 1'b0;
      chk("contention_grants", 64'(seq.size()), 64'(4));
      foreach (seq[i]) chk("contention_order", 64'(seq[i]), 64'(i % 2));
      repeat (8) @(posedge clk);
      ld(8'h10, 8'hA5);
      ld(8'h20, 8'h13); ld(8'h21, 8'h05); ld(8'h22, 8'h00); ld(8'h23, 8'h00);
      fetch(8'h20, 32'h00000513, 1'b0, 6);
      ld(8'h30, 8'h01); ld(8'h31, 8'h45);
      fetch(8'h30, 32'h00004501, 1'b1, 4);
      ld(8'hFE, 8'h93); ld(8'hFF, 8'h00); ld(8'h00, 8'h10); ld(8'h01, 8'h00);
      fetch(8'hFE, 32'h00100093, 1'b0, 6);
      g = -1;
      @(posedge clk); #1;
      f_req = 1'b1;
      f_addr = 8'h20;
      for (int t = 0; t < 30; t++) begin
         @(negedge clk);
         if (f_gnt) begin g = cyc; break; end
      end
      if (g < 0) fail("abort_fetch_timeout");
      @(posedge clk); #1;
      f_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk); #1;
      chk_reset_outputs("abort");
      reset = 1'b1;
      repeat (12) @(posedge clk);
      lg = 1'b0;
      fg = 1'b0;
      for (int t = 0; t < 400; t++) begin
         @(posedge clk); #1;
         if (lg) ld_valid = 1'b0;
         if (fg) f_req = 1'b0;
         if (!ld_valid && $urandom_range(0, 2) == 0) begin
            ld_valid = 1'b1;
            ld_addr = 8'($urandom);
            ld_data = 8'($urandom);
         end
         if (!f_req && $urandom_range(0, 2) == 0) begin
            f_req = 1'b1;
            f_addr = 8'($urandom);
         end
         @(negedge clk);
         lg = ld_ready;
         fg = f_gnt;
      end
      @(posedge clk); #1;
      ld_valid = 1'b0;
      f_req = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      chk("wq_drained", 64'(wq.size()), 64'(0));
      chk("aq_drained", 64'(aq.size()), 64'(0));
      chk("rq_drained", 64'(rq.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
